// File: rtl/pc_sequencer.sv
// -----------------------------------------------------------------------------
// pc_sequencer
//
// Program-counter controller for the picoMIPS core. Owns the PC register and
// steps it through sequential fetch, conditional branch, a switch-gated wait
// (press then release of sw8) and halt. PCout addresses program memory.
//
// Optional build macro: SW_DEBOUNCE_EN
//   defined   : synchronised switch is filtered by a DEBOUNCE-cycle counter
//   undefined : FSM uses the 2-flop synchronised switch directly
//
// Ports
//   clk            : system clock, rising edge
//   reset          : synchronous active-low reset
//   is_halt        : decoded HALT strobe
//   is_wait        : decoded WAIT strobe (stall until sw8 pressed+released)
//   is_branch      : decoded conditional branch strobe
//   flag           : branch condition, taken when 1
//   branch_target  : absolute branch destination
//   sw8            : raw asynchronous board switch, 1 = pressed
//   PCout          : current program counter
//   PCincr         : next PC is PCout+1 this cycle
//   waiting        : FSM in WAIT_PRESS or WAIT_RELEASE
//   halted         : FSM in HALT
//   o_dbg_state    : raw FSM state (RUN=0, WAIT_PRESS=1, WAIT_RELEASE=2, HALT=3)
//
// Handshake: decode strobes are single-cycle qualifiers sampled only in RUN;
// there is no back-pressure, a strobe presented outside RUN is dropped.
// -----------------------------------------------------------------------------
module pc_sequencer #(
   parameter int Psize    = 6,
   parameter int DEBOUNCE = 8
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             is_halt,
   input  logic             is_wait,
   input  logic             is_branch,
   input  logic             flag,
   input  logic [Psize-1:0] branch_target,
   input  logic             sw8,
   output logic [Psize-1:0] PCout,
   output logic             PCincr,
   output logic             waiting,
   output logic             halted,
   output logic [1:0]       o_dbg_state
);

   typedef enum logic [1:0] {
      S_RUN          = 2'd0,
      S_WAIT_PRESS   = 2'd1,
      S_WAIT_RELEASE = 2'd2,
      S_HALT         = 2'd3
   } state_t;

   localparam logic [Psize-1:0] PC_ONE = {{(Psize-1){1'b0}}, 1'b1};

   // Elaboration-time range check on the debounce length.
   if (DEBOUNCE < 2 || DEBOUNCE > 255) begin : g_bad_debounce
      $error("pc_sequencer: DEBOUNCE must be in 2..255");
   end

   state_t           r_state;
   state_t           w_state_nxt;
   logic [Psize-1:0] r_pc;
   logic [Psize-1:0] w_pc_nxt;
   logic             w_incr;
   logic             r_sync1;
   logic             r_sync2;
   logic             w_sw_s;
   logic             w_sw;

   // Two-flop synchroniser for the asynchronous switch.
   always_ff @(posedge clk) begin
      if (!reset) begin
         r_sync1 <= 1'b0;
         r_sync2 <= 1'b0;
      end else begin
         r_sync1 <= sw8;
         r_sync2 <= r_sync1;
      end
   end

   assign w_sw_s = r_sync2;

`ifdef SW_DEBOUNCE_EN
   localparam int               CW       = $clog2(DEBOUNCE + 1);
   localparam logic [CW-1:0]    CNT_LAST = CW'(DEBOUNCE - 1);
   localparam logic [CW-1:0]    CNT_ONE  = CW'(1);

   logic [CW-1:0] r_db_cnt;
   logic          r_sw_f;

   // Filtered switch flips only after DEBOUNCE consecutive cycles of
   // disagreement; any agreement in between restarts the count.
   always_ff @(posedge clk) begin
      if (!reset) begin
         r_db_cnt <= '0;
         r_sw_f   <= 1'b0;
      end else if (w_sw_s == r_sw_f) begin
         r_db_cnt <= '0;
      end else if (r_db_cnt == CNT_LAST) begin
         r_db_cnt <= '0;
         r_sw_f   <= w_sw_s;
      end else begin
         r_db_cnt <= r_db_cnt + CNT_ONE;
      end
   end

   assign w_sw = r_sw_f;
`else
   assign w_sw = w_sw_s;
`endif

   // State and PC registers.
   always_ff @(posedge clk) begin
      if (!reset) begin
         r_state <= S_RUN;
         r_pc    <= '0;
      end else begin
         r_state <= w_state_nxt;
         r_pc    <= w_pc_nxt;
      end
   end

   // Next-state / next-PC. Priority in RUN: halt > wait > taken branch > +1.
   always_comb begin
      w_state_nxt = r_state;
      w_pc_nxt    = r_pc;
      w_incr      = 1'b0;
      unique case (r_state)
         S_RUN: begin
            if (is_halt) begin
               w_state_nxt = S_HALT;
            end else if (is_wait) begin
               w_state_nxt = S_WAIT_PRESS;
            end else if (is_branch && flag) begin
               w_pc_nxt = branch_target;
            end else begin
               w_pc_nxt = r_pc + PC_ONE;
               w_incr   = 1'b1;
            end
         end
         S_WAIT_PRESS: begin
            if (w_sw) begin
               w_state_nxt = S_WAIT_RELEASE;
            end
         end
         S_WAIT_RELEASE: begin
            if (!w_sw) begin
               w_state_nxt = S_RUN;
               w_pc_nxt    = r_pc + PC_ONE;
               w_incr      = 1'b1;
            end
         end
         S_HALT: begin
            w_state_nxt = S_HALT;
         end
         default: begin
            w_state_nxt = S_RUN;
         end
      endcase
   end

   // A cycle with reset asserted never advances sequentially.
   assign PCincr      = w_incr & reset;
   assign PCout       = r_pc;
   assign waiting     = (r_state == S_WAIT_PRESS) || (r_state == S_WAIT_RELEASE);
   assign halted      = (r_state == S_HALT);
   assign o_dbg_state = r_state;

endmodule

// File: tb/tb_pc_sequencer.sv
// -----------------------------------------------------------------------------
// tb_pc_sequencer
//
// Self-checking bench for pc_sequencer. Each scenario task builds a list of
// per-cycle steps (inputs plus the outputs expected in that cycle), drives
// them one cycle at a time, pushes the expectation to exp_q and pops it when
// the outputs are sampled #1 after the drive, ahead of the next rising edge.
// Expected vector layout: {state[1:0], pc[5:0], incr, waiting, halted}.
// -----------------------------------------------------------------------------
module tb_pc_sequencer;

   localparam int PS = 6;
   localparam int DB = 4;
`ifdef SW_DEBOUNCE_EN
   localparam int LAT = 2 + DB;
`else
   localparam int LAT = 2;
`endif
   localparam int W = 11;

   localparam logic [1:0] ST_RUN  = 2'd0;
   localparam logic [1:0] ST_WP   = 2'd1;
   localparam logic [1:0] ST_WR   = 2'd2;
   localparam logic [1:0] ST_HALT = 2'd3;

   typedef struct packed {
      logic          rst;
      logic          h;
      logic          w;
      logic          b;
      logic          f;
      logic [PS-1:0] t;
      logic          s;
      logic [W-1:0]  exp;
   } step_t;

   // ---------------- clock / reset / DUT ----------------
   logic          clk;
   logic          reset;
   logic          is_halt;
   logic          is_wait;
   logic          is_branch;
   logic          flag;
   logic [PS-1:0] branch_target;
   logic          sw8;
   logic [PS-1:0] PCout;
   logic          PCincr;
   logic          waiting;
   logic          halted;
   logic [1:0]    o_dbg_state;

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   pc_sequencer #(.Psize(PS), .DEBOUNCE(DB)) dut (
      .clk           (clk),
      .reset         (reset),
      .is_halt       (is_halt),
      .is_wait       (is_wait),
      .is_branch     (is_branch),
      .flag          (flag),
      .branch_target (branch_target),
      .sw8           (sw8),
      .PCout         (PCout),
      .PCincr        (PCincr),
      .waiting       (waiting),
      .halted        (halted),
      .o_dbg_state   (o_dbg_state)
   );

   // ---------------- scoreboard state ----------------
   logic [W-1:0] exp_q[$];
   step_t        st_q[$];
   int           n_checks = 0;
   int           n_errors = 0;

   function automatic step_t mk(input logic rst, input logic h, input logic w,
                                input logic b, input logic f, input logic [PS-1:0] t,
                                input logic s, input logic [1:0] est,
                                input logic [PS-1:0] epc, input logic einc);
      step_t r;
      r.rst = rst;
      r.h   = h;
      r.w   = w;
      r.b   = b;
      r.f   = f;
      r.t   = t;
      r.s   = s;
      r.exp = {est, epc, einc, (est == ST_WP) || (est == ST_WR), est == ST_HALT};
      return r;
   endfunction

   function automatic step_t idle(input logic s, input logic [1:0] est,
                                  input logic [PS-1:0] epc, input logic einc);
      return mk(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, '0, s, est, epc, einc);
   endfunction

   // ---------------- driver tasks ----------------
   task automatic drive(input step_t s);
      reset         = s.rst;
      is_halt       = s.h;
      is_wait       = s.w;
      is_branch     = s.b;
      flag          = s.f;
      branch_target = s.t;
      sw8           = s.s;
   endtask

   // From WAIT_RELEASE with the switch still pressed: release and return to RUN.
   task automatic add_release(input logic [PS-1:0] pc);
      for (int i = 0; i < LAT; i++) st_q.push_back(idle(1'b0, ST_WR, pc, 1'b0));
      st_q.push_back(idle(1'b0, ST_WR, pc, 1'b1));
      st_q.push_back(idle(1'b0, ST_RUN, pc + 6'd1, 1'b1));
   endtask

   // From WAIT_PRESS: hold the switch for 'hold' cycles (with junk decode
   // strobes that must be ignored), then release.
   task automatic add_press_release(input logic [PS-1:0] pc, input int hold);
      for (int i = 0; i < hold; i++) begin
         st_q.push_back(mk(1'b1, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                           1'b1, 1'b1, 6'($urandom_range(0, 63)), 1'b1,
                           (i <= LAT) ? ST_WP : ST_WR, pc, 1'b0));
      end
      add_release(pc);
   endtask

   // ---------------- scenarios ----------------
   task automatic test_reset();
      step_t        cur;
      logic [W-1:0] got;
      logic [W-1:0] exp;
      int           idx = 0;
      drive(idle(1'b0, ST_RUN, '0, 1'b0));
      reset = 1'b0;
      @(posedge clk);
      @(posedge clk);
      @(negedge clk);
      st_q.push_back(mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, '0, 1'b0, ST_RUN, 6'd0, 1'b0));
      st_q.push_back(idle(1'b0, ST_RUN, 6'd0, 1'b1));
      while (st_q.size() > 0) begin
         cur = st_q.pop_front();
         drive(cur);
         exp_q.push_back(cur.exp);
         #1;
         got = {o_dbg_state, PCout, PCincr, waiting, halted};
         exp = exp_q.pop_front();
         n_checks++;
         if (got !== exp) begin
            n_errors++;
            $display("FAIL test_reset step %0d: got=%h expected=%h (state,pc,incr,wait,halt)", idx, got, exp);
         end
         @(posedge clk);
         @(negedge clk);
         idx++;
      end
   endtask

   task automatic test_increment();
      step_t        cur;
      logic [W-1:0] got;
      logic [W-1:0] exp;
      int           idx = 0;
      for (int i = 1; i <= 70; i++) st_q.push_back(idle(1'b0, ST_RUN, 6'(i % 64), 1'b1));
      while (st_q.size() > 0) begin
         cur = st_q.pop_front();
         drive(cur);
         exp_q.push_back(cur.exp);
         #1;
         got = {o_dbg_state, PCout, PCincr, waiting, halted};
         exp = exp_q.pop_front();
         n_checks++;
         if (got !== exp) begin
            n_errors++;
            $display("FAIL test_increment step %0d: got=%h expected=%h (state,pc,incr,wait,halt)", idx, got, exp);
         end
         @(posedge clk);
         @(negedge clk);
         idx++;
      end
   endtask

   // Starts at PC 7.
   task automatic test_branch();
      step_t        cur;
      logic [W-1:0] got;
      logic [W-1:0] exp;
      int           idx = 0;
      st_q.push_back(mk(1, 0, 0, 1, 1, 6'd5,  0, ST_RUN, 6'd7,  0));
      st_q.push_back(mk(1, 0, 0, 1, 1, 6'd40, 0, ST_RUN, 6'd5,  0));
      st_q.push_back(idle(0, ST_RUN, 6'd40, 1));
      st_q.push_back(mk(1, 0, 0, 1, 1, 6'd5,  0, ST_RUN, 6'd41, 0));
      st_q.push_back(mk(1, 0, 0, 1, 0, 6'd40, 0, ST_RUN, 6'd5,  1));
      st_q.push_back(idle(0, ST_RUN, 6'd6, 1));
      st_q.push_back(mk(1, 0, 0, 1, 1, 6'd7,  0, ST_RUN, 6'd7,  0));
      st_q.push_back(idle(0, ST_RUN, 6'd7, 1));
      while (st_q.size() > 0) begin
         cur = st_q.pop_front();
         drive(cur);
         exp_q.push_back(cur.exp);
         #1;
         got = {o_dbg_state, PCout, PCincr, waiting, halted};
         exp = exp_q.pop_front();
         n_checks++;
         if (got !== exp) begin
            n_errors++;
            $display("FAIL test_branch step %0d: got=%h expected=%h (state,pc,incr,wait,halt)", idx, got, exp);
         end
         @(posedge clk);
         @(negedge clk);
         idx++;
      end
   endtask

   // Starts at PC 8, ends at PC 12.
   task automatic test_wait();
      step_t        cur;
      logic [W-1:0] got;
      logic [W-1:0] exp;
      int           idx = 0;
      st_q.push_back(mk(1, 0, 0, 1, 1, 6'd10, 0, ST_RUN, 6'd8,  0));
      st_q.push_back(mk(1, 0, 1, 0, 0, 6'd0,  0, ST_RUN, 6'd10, 0));
      st_q.push_back(idle(0, ST_WP, 6'd10, 0));
      st_q.push_back(idle(0, ST_WP, 6'd10, 0));
`ifdef SW_DEBOUNCE_EN
      for (int i = 0; i < DB - 1; i++) st_q.push_back(idle(1, ST_WP, 6'd10, 0));
      for (int i = 0; i < DB + 3; i++) st_q.push_back(idle(0, ST_WP, 6'd10, 0));
`endif
      add_press_release(6'd10, LAT + 3);
      while (st_q.size() > 0) begin
         cur = st_q.pop_front();
         drive(cur);
         exp_q.push_back(cur.exp);
         #1;
         got = {o_dbg_state, PCout, PCincr, waiting, halted};
         exp = exp_q.pop_front();
         n_checks++;
         if (got !== exp) begin
            n_errors++;
            $display("FAIL test_wait step %0d: got=%h expected=%h (state,pc,incr,wait,halt)", idx, got, exp);
         end
         @(posedge clk);
         @(negedge clk);
         idx++;
      end
   endtask

   // Starts at PC 12, ends in HALT at PC 7.
   task automatic test_priority();
      step_t        cur;
      logic [W-1:0] got;
      logic [W-1:0] exp;
      int           idx = 0;
      st_q.push_back(mk(1, 0, 0, 1, 1, 6'd7,  0, ST_RUN, 6'd12, 0));
      st_q.push_back(mk(1, 1, 1, 1, 1, 6'd30, 0, ST_RUN, 6'd7,  0));
      for (int i = 0; i < 8; i++) begin
         st_q.push_back(mk(1'b1, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                           1'b1, 1'b1, 6'($urandom_range(0, 63)), 1'(i[1]),
                           ST_HALT, 6'd7, 1'b0));
      end
      while (st_q.size() > 0) begin
         cur = st_q.pop_front();
         drive(cur);
         exp_q.push_back(cur.exp);
         #1;
         got = {o_dbg_state, PCout, PCincr, waiting, halted};
         exp = exp_q.pop_front();
         n_checks++;
         if (got !== exp) begin
            n_errors++;
            $display("FAIL test_priority step %0d: got=%h expected=%h (state,pc,incr,wait,halt)", idx, got, exp);
         end
         @(posedge clk);
         @(negedge clk);
         idx++;
      end
   endtask

   // Starts in HALT at PC 7, ends at PC 2.
   task automatic test_reset_mid();
      step_t        cur;
      logic [W-1:0] got;
      logic [W-1:0] exp;
      int           idx = 0;
      st_q.push_back(mk(0, 1, 0, 0, 0, 6'd0, 0, ST_HALT, 6'd7, 0));
      st_q.push_back(idle(0, ST_RUN, 6'd0, 1));
      st_q.push_back(mk(1, 0, 0, 1, 1, 6'd20, 0, ST_RUN, 6'd1,  0));
      st_q.push_back(mk(1, 0, 1, 0, 0, 6'd0,  0, ST_RUN, 6'd20, 0));
      for (int i = 0; i <= LAT + 1; i++)
         st_q.push_back(idle(1, (i <= LAT) ? ST_WP : ST_WR, 6'd20, 0));
      st_q.push_back(mk(0, 0, 0, 0, 0, 6'd0, 1, ST_WR, 6'd20, 0));
      st_q.push_back(idle(0, ST_RUN, 6'd0, 1));
      st_q.push_back(idle(0, ST_RUN, 6'd1, 1));
      while (st_q.size() > 0) begin
         cur = st_q.pop_front();
         drive(cur);
         exp_q.push_back(cur.exp);
         #1;
         got = {o_dbg_state, PCout, PCincr, waiting, halted};
         exp = exp_q.pop_front();
         n_checks++;
         if (got !== exp) begin
            n_errors++;
            $display("FAIL test_reset_mid step %0d: got=%h expected=%h (state,pc,incr,wait,halt)", idx, got, exp);
         end
         @(posedge clk);
         @(negedge clk);
         idx++;
      end
   endtask

   // Starts at PC 2: wait beats branch, then a press already held on entry.
   task automatic test_wait_branch();
      step_t         cur;
      logic [W-1:0]  got;
      logic [W-1:0]  exp;
      logic [PS-1:0] x;
      int            idx = 0;
      st_q.push_back(mk(1, 0, 0, 1, 1, 6'd3,  0, ST_RUN, 6'd2, 0));
      st_q.push_back(mk(1, 0, 1, 1, 1, 6'd50, 0, ST_RUN, 6'd3, 0));
      st_q.push_back(idle(0, ST_WP, 6'd3, 0));
      add_press_release(6'd3, LAT + 1);
      for (int i = 0; i <= LAT; i++) st_q.push_back(idle(1, ST_RUN, 6'(5 + i), 1));
      x = 6'(5 + LAT + 1);
      st_q.push_back(mk(1, 0, 1, 0, 0, 6'd0, 1, ST_RUN, x, 0));
      st_q.push_back(idle(1, ST_WP, x, 0));
      st_q.push_back(idle(1, ST_WR, x, 0));
      add_release(x);
      while (st_q.size() > 0) begin
         cur = st_q.pop_front();
         drive(cur);
         exp_q.push_back(cur.exp);
         #1;
         got = {o_dbg_state, PCout, PCincr, waiting, halted};
         exp = exp_q.pop_front();
         n_checks++;
         if (got !== exp) begin
            n_errors++;
            $display("FAIL test_wait_branch step %0d: got=%h expected=%h (state,pc,incr,wait,halt)", idx, got, exp);
         end
         @(posedge clk);
         @(negedge clk);
         idx++;
      end
   endtask

   // ---------------- watchdog ----------------
   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached, got no end, expected end of tests");
      $fatal(1, "watchdog");
   end

   // ---------------- main sequence and report ----------------
   initial begin
      drive(idle(1'b0, ST_RUN, '0, 1'b0));
      reset = 1'b0;
      @(negedge clk);
      test_reset();
      test_increment();
      test_branch();
      test_wait();
      test_priority();
      test_reset_mid();
      test_wait_branch();
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
